am2950: RTL

Eight-bit (parameterizable) registered bidirectional I/O port with handshake flags. It sits directly upstream of the am2947 transceiver: port `a` faces the am2947 `b` side, and port `b` faces the local microprocessor or bitslice data bus. Two independent holding registers carry data in each direction:
- R register: `a` to `b`.
- S register: `b` to `a`.

Each register has a ready flag, so two asynchronous agents can exchange words without losing data.

---
 rtl/am2950_pkg.sv | 11 +
 rtl/am2950_if.sv | 33 +++
 rtl/am2950_half.sv | 62 ++++++
 rtl/am2950.sv | 43 ++++
 4 files changed

// File: rtl/am2950_pkg.sv
// Shared definitions for the am2950 registered bidirectional port: flag states and default width.
package am2950_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } flag_state_e;

  localparam int AM2950_WIDTH = 8;

endpackage

// File: rtl/am2950_if.sv
// Handshake strobes and ready flags of the am2950. ovr/ovs exist only with AM2950_OVERRUN_EN.
interface am2950_if;

  logic cer_;
  logic ces_;
  logic oer_;
  logic oes_;
  logic clrr_;
  logic clrs_;
  logic fr;
  logic fs;
`ifdef AM2950_OVERRUN_EN
  logic ovr;
  logic ovs;
`endif

  modport master (
    output cer_, ces_, oer_, oes_, clrr_, clrs_,
`ifdef AM2950_OVERRUN_EN
    input  ovr, ovs,
`endif
    input  fr, fs
  );

  modport slave (
    input  cer_, ces_, oer_, oes_, clrr_, clrs_,
`ifdef AM2950_OVERRUN_EN
    output ovr, ovs,
`endif
    output fr, fs
  );

endinterface

// File: rtl/am2950_half.sv
// One direction of the am2950: holding register, EMPTY/FULL flag, tristate driver.
// With AM2950_OVERRUN_EN an overrun sticky is added.
module am2950_half
  import am2950_pkg::*;
#(
  parameter int WIDTH = AM2950_WIDTH
) (
  input  logic             clk,
  input  logic             rst_,
  input  wire  [WIDTH-1:0] din,
  input  logic             ce_,
  input  logic             clr_,
  input  logic             oe_,
  output wire  [WIDTH-1:0] dout,
  output logic             flag
`ifdef AM2950_OVERRUN_EN
  ,
  output logic             ovf
`endif
);

  flag_state_e      r_state;
  flag_state_e      w_state_nxt;
  logic [WIDTH-1:0] r_data;

  always_ff @(posedge clk) begin
    if (!rst_) r_state <= EMPTY;
    else       r_state <= w_state_nxt;
  end

  // A load beats a same-edge clear so the incoming word is never dropped.
  always_comb begin
    w_state_nxt = r_state;
    if (!ce_)       w_state_nxt = FULL;
    else if (!clr_) w_state_nxt = EMPTY;
  end

  always_comb begin
    flag = (r_state == FULL);
  end

  always_ff @(posedge clk) begin
    if (!rst_)     r_data <= '0;
    else if (!ce_) r_data <= din;
  end

`ifdef AM2950_OVERRUN_EN
  logic r_ovf;

  // Set only when an unacknowledged word is overwritten; cleared only by a plain acknowledge.
  always_ff @(posedge clk) begin
    if (!rst_)                                r_ovf <= 1'b0;
    else if (!ce_ && clr_ && r_state == FULL) r_ovf <= 1'b1;
    else if (ce_ && !clr_)                    r_ovf <= 1'b0;
  end

  assign ovf = r_ovf;
`endif

  assign dout = oe_ ? {WIDTH{1'bz}} : r_data;

endmodule

// File: rtl/am2950.sv
// am2950 registered bidirectional I/O port: R carries a->b, S carries b->a.
// Define AM2950_OVERRUN_EN to add the ovr/ovs overrun stickies.
module am2950
  import am2950_pkg::*;
#(
  parameter int WIDTH = AM2950_WIDTH
) (
  input  logic             clk,
  input  logic             rst_,
  inout  wire  [WIDTH-1:0] a,
  inout  wire  [WIDTH-1:0] b,
  am2950_if.slave          bus
);

  am2950_half #(.WIDTH(WIDTH)) u_r (
    .clk  (clk),
    .rst_ (rst_),
    .din  (a),
    .ce_  (bus.cer_),
    .clr_ (bus.clrr_),
    .oe_  (bus.oer_),
    .dout (b),
`ifdef AM2950_OVERRUN_EN
    .ovf  (bus.ovr),
`endif
    .flag (bus.fr)
  );

  am2950_half #(.WIDTH(WIDTH)) u_s (
    .clk  (clk),
    .rst_ (rst_),
    .din  (b),
    .ce_  (bus.ces_),
    .clr_ (bus.clrs_),
    .oe_  (bus.oes_),
    .dout (a),
`ifdef AM2950_OVERRUN_EN
    .ovf  (bus.ovs),
`endif
    .flag (bus.fs)
  );

endmodule
